// File: rtl/gt_link_init_fsm.sv
// GT link bring-up controller: full reset, TX/RX wait with timeouts,
// bounded RX datapath retries and a debounce before declaring link_up.
module gt_link_init_fsm #(
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter int unsigned TX_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RX_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RX_RESET_CYCLES   = 16,
  parameter int unsigned MAX_RX_RETRIES    = 3,
  parameter int unsigned DEBOUNCE_CYCLES   = 256
) (
  input  logic       init_clk,
  input  logic       rst,
  input  logic       tx_good_init_synced,
  input  logic       rx_good_init_synced,
  output logic       gt_reset_all,
  output logic       gt_rx_reset_datapath,
  output logic       link_up,
  output logic [7:0] full_reset_cnt,
  output logic [2:0] fsm_state
);

  localparam int unsigned MAX_AB  = (RESET_HOLD_CYCLES > TX_TIMEOUT_CYCLES) ?
                                    RESET_HOLD_CYCLES : TX_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD  = (RX_TIMEOUT_CYCLES > RX_RESET_CYCLES) ?
                                    RX_TIMEOUT_CYCLES : RX_RESET_CYCLES;
  localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_CYC = (MAX_ABCD > DEBOUNCE_CYCLES) ? MAX_ABCD : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TX_LAST    = CNT_W'(TX_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RX_LAST    = CNT_W'(RX_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RXR_LAST   = CNT_W'(RX_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_ALL = 3'd0,
    S_WAIT_TX   = 3'd1,
    S_WAIT_RX   = 3'd2,
    S_RX_RESET  = 3'd3,
    S_DEBOUNCE  = 3'd4,
    S_LINK_UP   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] rx_retry, rx_retry_nxt;
  logic [7:0]         full_reset_cnt_nxt;
  logic               fault;

  wire tx_good = tx_good_init_synced;
  wire rx_good = rx_good_init_synced;

  // Next-state, cycle counter, retry budget and fault accounting.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt + CNT_W'(1);
    rx_retry_nxt       = rx_retry;
    fault              = 1'b0;
    full_reset_cnt_nxt = full_reset_cnt;

    case (state)
      S_RESET_ALL: begin
        if (cnt == HOLD_LAST) begin
          state_nxt    = S_WAIT_TX;
          rx_retry_nxt = '0;
        end
      end
      S_WAIT_TX: begin
        if (tx_good)             state_nxt = S_WAIT_RX;
        else if (cnt == TX_LAST) fault     = 1'b1;
      end
      S_WAIT_RX: begin
        if (!tx_good)     fault     = 1'b1;
        else if (rx_good) state_nxt = S_DEBOUNCE;
        else if (cnt == RX_LAST) begin
          if (rx_retry == RETRY_MAX) begin
            fault = 1'b1;
          end else begin
            rx_retry_nxt = rx_retry + RETRY_W'(1);
            state_nxt    = S_RX_RESET;
          end
        end
      end
      S_RX_RESET: begin
        if (!tx_good)             fault     = 1'b1;
        else if (cnt == RXR_LAST) state_nxt = S_WAIT_RX;
      end
      S_DEBOUNCE: begin
        if (!tx_good)      fault     = 1'b1;
        else if (!rx_good) state_nxt = S_WAIT_RX;
        else if (cnt == DB_LAST) begin
          state_nxt    = S_LINK_UP;
          rx_retry_nxt = '0;
        end
      end
      S_LINK_UP: begin
        // Steady state has no limit, so the counter holds instead of wrapping.
        cnt_nxt = cnt;
        if (!tx_good) fault = 1'b1;
        else if (!rx_good) begin
          if (rx_retry == RETRY_MAX) begin
            fault = 1'b1;
          end else begin
            rx_retry_nxt = rx_retry + RETRY_W'(1);
            state_nxt    = S_RX_RESET;
          end
        end
      end
      default: state_nxt = S_RESET_ALL;
    endcase

    if (fault) begin
      state_nxt = S_RESET_ALL;
      if (full_reset_cnt != 8'hFF) full_reset_cnt_nxt = full_reset_cnt + 8'd1;
    end
    if (state_nxt != state) cnt_nxt = '0;
  end

  // State register; outputs are decoded from the current state one edge later.
  always_ff @(posedge init_clk) begin
    if (rst) begin
      state                <= S_RESET_ALL;
      cnt                  <= '0;
      rx_retry             <= '0;
      full_reset_cnt       <= 8'd0;
      gt_reset_all         <= 1'b1;
      gt_rx_reset_datapath <= 1'b0;
      link_up              <= 1'b0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      rx_retry             <= rx_retry_nxt;
      full_reset_cnt       <= full_reset_cnt_nxt;
      gt_reset_all         <= (state == S_RESET_ALL);
      gt_rx_reset_datapath <= (state == S_RX_RESET);
      link_up              <= (state == S_LINK_UP);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_gt_link_init_fsm.sv
// Directed bench for gt_link_init_fsm with a per-edge expectation scoreboard.
module tb_gt_link_init_fsm;

  localparam int unsigned RH  = 4;
  localparam int unsigned TXT = 20;
  localparam int unsigned RXT = 30;
  localparam int unsigned RXR = 5;
  localparam int unsigned MR  = 2;
  localparam int unsigned DBC = 8;

  localparam logic [2:0] RA = 3'd0;
  localparam logic [2:0] WT = 3'd1;
  localparam logic [2:0] WR = 3'd2;
  localparam logic [2:0] RR = 3'd3;
  localparam logic [2:0] DB = 3'd4;
  localparam logic [2:0] LU = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       gra;
    logic       grr;
    logic       lu;
    logic [7:0] frc;
  } exp_t;

  logic       init_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_good = 1'b0;
  logic       rx_good = 1'b0;
  logic       gt_reset_all;
  logic       gt_rx_reset_datapath;
  logic       link_up;
  logic [7:0] full_reset_cnt;
  logic [2:0] fsm_state;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [2:0] prev_st = RA;

  always #5 init_clk = ~init_clk;

  gt_link_init_fsm #(
    .RESET_HOLD_CYCLES(RH),
    .TX_TIMEOUT_CYCLES(TXT),
    .RX_TIMEOUT_CYCLES(RXT),
    .RX_RESET_CYCLES(RXR),
    .MAX_RX_RETRIES(MR),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .init_clk(init_clk),
    .rst(rst),
    .tx_good_init_synced(tx_good),
    .rx_good_init_synced(rx_good),
    .gt_reset_all(gt_reset_all),
    .gt_rx_reset_datapath(gt_rx_reset_datapath),
    .link_up(link_up),
    .full_reset_cnt(full_reset_cnt),
    .fsm_state(fsm_state)
  );

  // Outputs reflect the state held during the previous cycle.
  function automatic exp_t make_exp(input logic [2:0] st, input logic [2:0] from,
                                    input logic [7:0] frc);
    exp_t e;
    e.st  = st;
    e.gra = (from == RA);
    e.grr = (from == RR);
    e.lu  = (from == LU);
    e.frc = frc;
    return e;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [7:0] got,
                     input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s got=%0h want=%0h", tag, fld, got, want);
    end
  endtask

  task automatic tick();
    @(posedge init_clk);
    #1;
  endtask

  task automatic check_top(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty got=- want=entry", tag);
    end else begin
      e = sb.pop_front();
      cmp(tag, "state", 8'(fsm_state), 8'(e.st));
      cmp(tag, "gt_reset_all", 8'(gt_reset_all), 8'(e.gra));
      cmp(tag, "gt_rx_reset_datapath", 8'(gt_rx_reset_datapath), 8'(e.grr));
      cmp(tag, "link_up", 8'(link_up), 8'(e.lu));
      cmp(tag, "full_reset_cnt", full_reset_cnt, e.frc);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [7:0] frc);
    sb.push_back(make_exp(st, prev_st, frc));
    tick();
    check_top(tag);
    prev_st = st;
  endtask

  task automatic hold(input string tag, input int n, input logic [2:0] st,
                      input logic [7:0] frc);
    for (int i = 0; i < n; i++) step(tag, st, frc);
  endtask

  task automatic rst_step(input string tag);
    rst = 1'b1;
    sb.push_back(make_exp(RA, RA, 8'd0));
    tick();
    check_top(tag);
    prev_st = RA;
  endtask

  initial begin
    // 1: reset, bring-up with both goods high
    tx_good = 1'b1;
    rx_good = 1'b1;
    repeat (3) rst_step("t1_rst");
    rst = 1'b0;
    hold("t1_ra", 3, RA, 8'd0);
    step("t1_wt", WT, 8'd0);
    step("t1_wr", WR, 8'd0);
    step("t1_db_in", DB, 8'd0);
    hold("t1_db", 7, DB, 8'd0);
    step("t1_lu_st", LU, 8'd0);
    step("t1_lu", LU, 8'd0);

    // 4: one-cycle rx_good drop from LINK_UP
    rx_good = 1'b0;
    step("t4_drop", RR, 8'd0);
    rx_good = 1'b1;
    step("t4_lu_low", RR, 8'd0);
    hold("t4_rr", 3, RR, 8'd0);
    step("t4_wr", WR, 8'd0);
    step("t4_db_in", DB, 8'd0);
    hold("t4_db", 7, DB, 8'd0);
    step("t4_lu_st", LU, 8'd0);
    step("t4_lu", LU, 8'd0);

    // 5: both goods fall together, full reset wins
    tx_good = 1'b0;
    rx_good = 1'b0;
    step("t5_drop", RA, 8'd1);
    step("t5_ra", RA, 8'd1);

    // 3: rx never good, two RX resets then escalation
    tx_good = 1'b1;
    hold("t3_ra", 2, RA, 8'd1);
    step("t3_wt", WT, 8'd1);
    step("t3_wr", WR, 8'd1);
    hold("t3_wr_a", RXT - 1, WR, 8'd1);
    step("t3_rr1", RR, 8'd1);
    hold("t3_rr1_h", RXR - 1, RR, 8'd1);
    step("t3_wr_b_in", WR, 8'd1);
    hold("t3_wr_b", RXT - 1, WR, 8'd1);
    step("t3_rr2", RR, 8'd1);
    hold("t3_rr2_h", RXR - 1, RR, 8'd1);
    step("t3_wr_c_in", WR, 8'd1);
    hold("t3_wr_c", RXT - 1, WR, 8'd1);
    step("t3_esc", RA, 8'd2);
    tx_good = 1'b1;
    rx_good = 1'b1;
    step("t3_esc_gra", RA, 8'd2);

    // 6: debounce glitch costs no retry; rst during RX_RESET
    hold("t6_ra", 2, RA, 8'd2);
    step("t6_wt", WT, 8'd2);
    step("t6_wr", WR, 8'd2);
    step("t6_db_in", DB, 8'd2);
    hold("t6_db", 5, DB, 8'd2);
    rx_good = 1'b0;
    step("t6_glitch", WR, 8'd2);
    hold("t6_wr_a", RXT - 1, WR, 8'd2);
    step("t6_rr1", RR, 8'd2);
    hold("t6_rr1_h", RXR - 1, RR, 8'd2);
    step("t6_wr_b_in", WR, 8'd2);
    hold("t6_wr_b", RXT - 1, WR, 8'd2);
    step("t6_rr2", RR, 8'd2);
    step("t6_rr2_h", RR, 8'd2);
    rst_step("t6_rst");

    // 2: tx never good, periodic full resets and saturation
    rst = 1'b0;
    tx_good = 1'b0;
    rx_good = 1'b0;
    hold("t2_ra", 3, RA, 8'd0);
    step("t2_wt", WT, 8'd0);
    hold("t2_wt_h", TXT - 1, WT, 8'd0);
    step("t2_to1", RA, 8'd1);
    hold("t2_ra_b", 3, RA, 8'd1);
    step("t2_wt_b", WT, 8'd1);
    hold("t2_wt_b_h", TXT - 1, WT, 8'd1);
    step("t2_to2", RA, 8'd2);
    repeat (253 * (RH + TXT) - 1) tick();
    cmp("t2_sat254", "full_reset_cnt", full_reset_cnt, 8'd254);
    cmp("t2_sat254", "state", 8'(fsm_state), 8'(WT));
    tick();
    cmp("t2_sat255", "full_reset_cnt", full_reset_cnt, 8'd255);
    cmp("t2_sat255", "state", 8'(fsm_state), 8'(RA));
    repeat (RH + TXT) tick();
    cmp("t2_sat_hold", "full_reset_cnt", full_reset_cnt, 8'd255);
    cmp("t2_sat_hold", "state", 8'(fsm_state), 8'(RA));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
